// File: rtl/calc_sequencer.sv
// calc_sequencer: operand-entry / execution sequencer with integrated ALU.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   enter, clear, chain     step pulse, synchronous clear pulse, chain level
//   op_load, op_sel         latch a legal op code while in S_OPE
//   operand                 switch value
//   state                   one-hot {S_RES,S_EXEC,S_OPE,S_IN2,S_IN1}
//   op, flags               current op, {Z,N,C,V} of the last result
//   display_value           combinational value to show
//   busy, result_valid      high in S_EXEC, one-cycle pulse on result update
module calc_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enter,
    input  logic             clear,
    input  logic             chain,
    input  logic             op_load,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] operand,
    output logic [4:0]       state,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] display_value,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             result_valid
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    typedef enum logic [4:0] {
        S_IN1  = 5'b00001,
        S_IN2  = 5'b00010,
        S_OPE  = 5'b00100,
        S_EXEC = 5'b01000,
        S_RES  = 5'b10000
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] in1_q, in2_q, result_q;
    logic [3:0]       flags_q;
    logic [2:0]       op_q;
    logic             rv_q;
    logic [W2-1:0]    acc_q, mcd_q, acc_nxt;
    logic [WIDTH-1:0] mpl_q;
    logic [CW-1:0]    cnt_q;
    logic             exec_done;
    logic             op_sel_ok;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;

    // MUL finishes after WIDTH partial-product steps; other ops take one cycle.
    assign exec_done = (state_q == S_EXEC) &&
                       ((op_q != OP_MUL) || (cnt_q == CW'(WIDTH - 1)));
    assign op_sel_ok = op_sel inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IN1;
        else          state_q <= state_d;
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IN1;
        end else begin
            case (state_q)
                S_IN1:   if (enter) state_d = S_IN2;
                S_IN2:   if (enter) state_d = S_OPE;
                S_OPE:   if (enter) state_d = S_EXEC;
                S_EXEC:  if (exec_done) state_d = S_RES;
                S_RES:   if (enter) state_d = chain ? S_IN2 : S_IN1;
                default: state_d = S_IN1;
            endcase
        end
    end

    // Output logic: display source follows the state
    always_comb begin
        display_value = operand;
        case (state_q)
            S_OPE, S_EXEC: display_value = in2_q;
            S_RES:         display_value = result_q;
            default:       display_value = operand;
        endcase
    end

    // ALU: combinational ops plus one shift-add multiplier step
    always_comb begin
        sum     = {1'b0, in1_q} + {1'b0, in2_q};
        diff    = {1'b0, in1_q} - {1'b0, in2_q};
        acc_nxt = acc_q + (mpl_q[0] ? mcd_q : '0);
        alu_res = in1_q | in2_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (in1_q[WIDTH-1] == in2_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != in1_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (in1_q[WIDTH-1] != in2_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != in1_q[WIDTH-1]);
            end
            OP_MUL: begin
                alu_res = acc_nxt[WIDTH-1:0];
                alu_c   = |acc_nxt[W2-1:WIDTH];
                alu_v   = alu_c;
            end
            OP_AND:  alu_res = in1_q & in2_q;
            default: alu_res = in1_q | in2_q;
        endcase
        alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in1_q    <= '0;
            in2_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            op_q     <= OP_OR;
            rv_q     <= 1'b0;
            acc_q    <= '0;
            mcd_q    <= '0;
            mpl_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rv_q <= 1'b0;
            if (clear) begin
                in1_q    <= '0;
                in2_q    <= '0;
                result_q <= '0;
                flags_q  <= '0;
                cnt_q    <= '0;
            end else begin
                if (op_load && (state_q == S_OPE) && op_sel_ok) op_q <= op_sel;
                case (state_q)
                    S_IN1: if (enter) in1_q <= operand;
                    S_IN2: if (enter) in2_q <= operand;
                    S_OPE: if (enter) begin
                        // Multiplier is primed on every entry to S_EXEC
                        acc_q <= '0;
                        mcd_q <= {{WIDTH{1'b0}}, in1_q};
                        mpl_q <= in2_q;
                        cnt_q <= '0;
                    end
                    S_EXEC: begin
                        acc_q <= acc_nxt;
                        mcd_q <= mcd_q << 1;
                        mpl_q <= mpl_q >> 1;
                        cnt_q <= cnt_q + CW'(1);
                        if (exec_done) begin
                            result_q <= alu_res;
                            flags_q  <= alu_flags;
                            rv_q     <= 1'b1;
                        end
                    end
                    S_RES: if (enter && chain) in1_q <= result_q;
                    default: ;
                endcase
            end
        end
    end

    assign state        = state_q;
    assign op           = op_q;
    assign flags        = flags_q;
    assign busy         = (state_q == S_EXEC);
    assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: vector table, hand sequences, random vs model.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, enter, clear, chain, op_load;
    logic [2:0]  op_sel;
    logic [15:0] operand;
    logic [4:0]  state;
    logic [2:0]  op;
    logic [15:0] display_value;
    logic [3:0]  flags;
    logic        busy, result_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] ST_IN1 = 5'b00001, ST_IN2 = 5'b00010, ST_OPE = 5'b00100,
                           ST_RES = 5'b10000;

    calc_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .enter(enter), .clear(clear), .chain(chain),
        .op_load(op_load), .op_sel(op_sel), .operand(operand), .state(state),
        .op(op), .display_value(display_value), .flags(flags), .busy(busy),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
        int          cyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_val(input logic [15:0] v);
        operand = v;
        enter   = 1'b1;
        tick();
        enter   = 1'b0;
    endtask

    // Reference: {flags,result} from plain integer arithmetic
    function automatic logic [19:0] model(input logic [2:0] opc, input logic [15:0] a,
                                          input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        longint sr = 0;
        logic c = 1'b0, v = 1'b0;
        logic [15:0] res;
        case (opc)
            3'd1: begin r = ua + ub; c = (r > 65535); sr = sa + sb;
                        v = (sr > 32767) || (sr < -32768); end
            3'd2: begin r = ua - ub; c = (ua < ub); sr = sa - sb;
                        v = (sr > 32767) || (sr < -32768); end
            3'd3: begin r = ua * ub; c = ((r >> 16) != 0); v = c; end
            3'd4: r = ua & ub;
            default: r = ua | ub;
        endcase
        res = 16'(r);
        return {(res == 16'h0), res[15], c, v, res};
    endfunction

    // From S_OPE: load op together with enter, run to S_RES and check outcome
    task automatic exec_op(input logic [2:0] opc, input logic [15:0] er, input logic [3:0] ef,
                           input int ecyc, input string tag);
        int n = 0;
        bit early_rv = 0;
        op_sel  = opc;
        op_load = 1'b1;
        enter   = 1'b1;
        tick();
        op_load = 1'b0;
        enter   = 1'b0;
        while (busy && n < 40) begin
            n++;
            if (result_valid) early_rv = 1;
            tick();
        end
        chk({tag, " busy_cycles"}, 32'(n), 32'(ecyc));
        chk({tag, " rv_pulse"}, {31'd0, result_valid & ~early_rv}, 32'd1);
        chk({tag, " state_res"}, 32'(state), 32'(ST_RES));
        chk({tag, " result"}, 32'(display_value), 32'(er));
        chk({tag, " flags"}, 32'(flags), 32'(ef));
        tick();
        chk({tag, " rv_single"}, 32'(result_valid), 32'd0);
    endtask

    task automatic run_op(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef, input int ecyc,
                          input string tag);
        enter_val(a);
        enter_val(b);
        chk({tag, " disp_in2"}, 32'(display_value), 32'(b));
        exec_op(opc, er, ef, ecyc, tag);
        chain = 1'b0;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        logic [19:0] m;
        logic [2:0]  ropc;
        logic [15:0] ra, rb;
        int          n;
        bit          seen;

        vecs[0] = '{3'b001, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1};
        vecs[1] = '{3'b011, 16'd300,  16'd300,  16'h5F90, 4'b0011, 16};
        vecs[2] = '{3'b100, 16'h00F0, 16'h0F0F, 16'h0000, 4'b1000, 1};
        vecs[3] = '{3'b010, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1};
        vecs[4] = '{3'b101, 16'h1234, 16'h0F00, 16'h1F34, 4'b0000, 1};
        vecs[5] = '{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1};
        vecs[6] = '{3'b010, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1};
        vecs[7] = '{3'b011, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0011, 16};
        vecs[8] = '{3'b011, 16'h0000, 16'h1234, 16'h0000, 4'b1000, 16};

        reset_n = 1'b0; enter = 1'b0; clear = 1'b0; chain = 1'b0; op_load = 1'b0;
        op_sel = 3'b000; operand = 16'hA5A5;
        #12;
        chk("rst state", 32'(state), 32'(ST_IN1));
        chk("rst op", 32'(op), 32'd5);
        chk("rst flags", 32'(flags), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rv", 32'(result_valid), 32'd0);
        chk("rst display", 32'(display_value), 32'hA5A5);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg,
                   vecs[i].cyc, $sformatf("vec%0d", i));

        // Asynchronous reset pulse while in S_IN2 (op is MUL, flags nonzero)
        enter_val(16'h1111);
        chk("pre_rst state", 32'(state), 32'(ST_IN2));
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst state", 32'(state), 32'(ST_IN1));
        chk("arst op", 32'(op), 32'd5);
        chk("arst flags", 32'(flags), 32'd0);
        chk("arst display", 32'(display_value), 32'h1111);
        reset_n = 1'b1;
        tick();
        run_op(3'b001, 16'd7, 16'd9, 16'd16, 4'b0000, 1, "post_rst");

        // Chaining: 5+3=8, then 8-2=6
        run_op(3'b001, 16'd5, 16'd3, 16'd8, 4'b0000, 1, "chain_a");
        enter_val(16'd5);
        enter_val(16'd3);
        exec_op(3'b001, 16'd8, 4'b0000, 1, "chain_b");
        chain = 1'b1;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chain = 1'b0;
        chk("chain state", 32'(state), 32'(ST_IN2));
        enter_val(16'd2);
        exec_op(3'b010, 16'd6, 4'b0000, 1, "chain_sub");
        enter = 1'b1;
        tick();
        enter = 1'b0;

        // Op handling: ignored outside S_OPE and for illegal codes
        op_sel = 3'b100; op_load = 1'b1;
        tick();
        op_load = 1'b0;
        chk("opload in1", 32'(op), 32'd2);
        enter_val(16'h00F0);
        enter_val(16'h0F0F);
        op_sel = 3'b110; op_load = 1'b1;
        tick();
        op_load = 1'b0;
        chk("opload illegal", 32'(op), 32'd2);
        chk("opload state", 32'(state), 32'(ST_OPE));
        op_sel = 3'b100; op_load = 1'b1;
        tick();
        op_load = 1'b0;
        chk("opload and", 32'(op), 32'd4);
        exec_op(3'b100, 16'h0000, 4'b1000, 1, "and_z");
        enter = 1'b1;
        tick();
        enter = 1'b0;

        // Clear during cycle 5 of a MUL
        enter_val(16'd300);
        enter_val(16'd300);
        op_sel = 3'b011; op_load = 1'b1; enter = 1'b1;
        tick();
        op_load = 1'b0; enter = 1'b0;
        repeat (4) tick();
        chk("clr busy_before", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr state", 32'(state), 32'(ST_IN1));
        chk("clr flags", 32'(flags), 32'd0);
        chk("clr op", 32'(op), 32'd3);
        chk("clr busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (result_valid) seen = 1;
            tick();
        end
        chk("clr no_rv", {31'd0, seen}, 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ropc = 3'($urandom_range(1, 5));
            ra   = 16'($urandom);
            rb   = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            m    = model(ropc, ra, rb);
            n    = (ropc == 3'b011) ? 16 : 1;
            run_op(ropc, ra, rb, m[15:0], m[19:16], n, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
